// File: rtl/aerout_uart_framer.sv
// AER output framer: completes the 4-phase AEROUT handshake, timestamps each spike,
// buffers events in a FIFO and streams each event as 3 bytes (addr, ts_hi, ts_lo) over AXI-Stream.
module aerout_uart_framer #(
   parameter int FIFO_DEPTH   = 16,
   parameter int TS_PRESCALE  = 85,
   parameter bit DROP_ON_FULL = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    AEROUT_ADDR,
   input  logic                          AEROUT_REQ,
   output logic                          AEROUT_ACK,
   output logic [7:0]                    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   input  logic                          ts_clear,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    overflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;

   typedef enum logic {CAP_IDLE, CAP_ACK} cap_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_B0, TX_B1, TX_B2} tx_state_t;

   cap_state_t cap_state, cap_next;
   tx_state_t  tx_state, tx_next;

   logic [PW-1:0] prescaler;
   logic [15:0]   ts;
   logic [23:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [23:0]   hold;
   logic          full, empty, fifo_wr, fifo_rd, drop;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
   // combinational blocks use blocking (=).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         ts        <= '0;
      end else if (ts_clear) begin
         prescaler <= '0;
         ts        <= '0;
      end else if (prescaler == PW'(TS_PRESCALE - 1)) begin
         prescaler <= '0;
         ts        <= ts + 16'd1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      cap_next = cap_state;
      fifo_wr  = 1'b0;
      drop     = 1'b0;
      unique case (cap_state)
         CAP_IDLE:
            if (AEROUT_REQ) begin
               if (!full) begin
                  fifo_wr  = 1'b1;
                  cap_next = CAP_ACK;
               end else if (DROP_ON_FULL) begin
                  drop     = 1'b1;
                  cap_next = CAP_ACK;
               end
            end
         CAP_ACK:
            if (!AEROUT_REQ) cap_next = CAP_IDLE;
         default: cap_next = CAP_IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx_state;
      fifo_rd = 1'b0;
      unique case (tx_state)
         TX_IDLE:
            if (!empty) begin
               fifo_rd = 1'b1;
               tx_next = TX_B0;
            end
         TX_B0: if (m_axis_tready) tx_next = TX_B1;
         TX_B1: if (m_axis_tready) tx_next = TX_B2;
         TX_B2:
            if (m_axis_tready) begin
               if (!empty) begin
                  fifo_rd = 1'b1;
                  tx_next = TX_B0;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_state      <= CAP_IDLE;
         tx_state       <= TX_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         hold           <= '0;
         overflow_count <= '0;
      end else begin
         cap_state <= cap_next;
         tx_state  <= tx_next;
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold   <= mem[rd_ptr];
         end
         unique case ({fifo_wr, fifo_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= {AEROUT_ADDR, ts};
   end

   assign AEROUT_ACK    = (cap_state == CAP_ACK);
   assign m_axis_tvalid = (tx_state != TX_IDLE);
   assign fifo_level    = count;

   always_comb begin
      m_axis_tdata = 8'h00;
      unique case (tx_state)
         TX_B0:   m_axis_tdata = hold[23:16];
         TX_B1:   m_axis_tdata = hold[15:8];
         TX_B2:   m_axis_tdata = hold[7:0];
         default: m_axis_tdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_aerout_uart_framer.sv
// Directed bench for aerout_uart_framer: dut_a stalls when full (prescale 4),
// dut_b drops when full (prescale 1) and exercises the timestamp wrap.
module tb_aerout_uart_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [2];
   logic [7:0] addr [2];
   logic       req [2];
   logic       ack [2];
   logic [7:0] tdata [2];
   logic       tvalid [2];
   logic       tready [2];
   logic       ts_clear [2];
   logic [4:0] level [2];
   logic [7:0] ovf [2];

   int n_checks = 0;
   int n_pass   = 0;

   aerout_uart_framer #(.FIFO_DEPTH(16), .TS_PRESCALE(4), .DROP_ON_FULL(1'b0)) dut_a (
      .clk(clk), .rst(rst[0]), .AEROUT_ADDR(addr[0]), .AEROUT_REQ(req[0]), .AEROUT_ACK(ack[0]),
      .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
      .ts_clear(ts_clear[0]), .fifo_level(level[0]), .overflow_count(ovf[0]));

   aerout_uart_framer #(.FIFO_DEPTH(16), .TS_PRESCALE(1), .DROP_ON_FULL(1'b1)) dut_b (
      .clk(clk), .rst(rst[1]), .AEROUT_ADDR(addr[1]), .AEROUT_REQ(req[1]), .AEROUT_ACK(ack[1]),
      .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
      .ts_clear(ts_clear[1]), .fifo_level(level[1]), .overflow_count(ovf[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, " ack"}, ack[d], 0);
      check({tag, " tvalid"}, tvalid[d], 0);
      check({tag, " tdata"}, tdata[d], 0);
      check({tag, " level"}, level[d], 0);
      check({tag, " overflow"}, ovf[d], 0);
   endtask

   task automatic handshake(input int d, input logic [7:0] a, input string tag);
      int n;
      addr[d] = a;
      req[d]  = 1'b1;
      n = 0;
      do begin step(); n++; end while (!ack[d] && n < 100);
      check({tag, " ack rise"}, ack[d], 1);
      req[d] = 1'b0;
      n = 0;
      do begin step(); n++; end while (ack[d] && n < 100);
      check({tag, " ack fall"}, ack[d], 0);
   endtask

   task automatic recv_byte(input int d, output logic [7:0] b, input string tag);
      int n = 0;
      while (!tvalid[d] && n < 100) begin step(); n++; end
      check({tag, " tvalid"}, tvalid[d], 1);
      b = tdata[d];
      tready[d] = 1'b1;
      step();
      tready[d] = 1'b0;
   endtask

   task automatic recv_frame(input int d, input logic [7:0] a, input logic [15:0] t, input string tag);
      logic [7:0] b;
      recv_byte(d, b, tag); check({tag, " addr"}, b, a);
      recv_byte(d, b, tag); check({tag, " ts_hi"}, b, t[15:8]);
      recv_byte(d, b, tag); check({tag, " ts_lo"}, b, t[7:0]);
   endtask

   task automatic recv_addr(input int d, input logic [7:0] a, input string tag);
      logic [7:0] b;
      recv_byte(d, b, tag); check({tag, " addr"}, b, a);
      recv_byte(d, b, tag);
      recv_byte(d, b, tag);
   endtask

   initial begin
      int bad;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; addr[d] = 8'h00; req[d] = 1'b0; tready[d] = 1'b0; ts_clear[d] = 1'b0;
      end
      step(); step();
      check_idle(0, "reset a");
      check_idle(1, "reset b");
      rst[0] = 1'b0; rst[1] = 1'b0;
      step();

      // Single event at tick 3 with tready held high.
      tready[0] = 1'b1;
      ts_clear[0] = 1'b1; step(); ts_clear[0] = 1'b0;
      repeat (12) step();
      addr[0] = 8'h5A; req[0] = 1'b1;
      check("t1 ack before", ack[0], 0);
      step();
      check("t1 ack", ack[0], 1);
      check("t1 tvalid early", tvalid[0], 0);
      check("t1 level", level[0], 1);
      req[0] = 1'b0;
      step();
      check("t1 ack drop", ack[0], 0);
      check("t1 tvalid", tvalid[0], 1);
      check("t1 byte0", tdata[0], 8'h5A);
      check("t1 level drained", level[0], 0);
      step(); check("t1 byte1", tdata[0], 8'h00);
      step(); check("t1 byte2", tdata[0], 8'h03);
      step(); check("t1 tvalid end", tvalid[0], 0);
      tready[0] = 1'b0;

      // Backpressure in B1 for 50 cycles, ts = 0x0123.
      ts_clear[0] = 1'b1; step(); ts_clear[0] = 1'b0;
      repeat (4 * 'h123) step();
      handshake(0, 8'hC3, "t2");
      begin
         logic [7:0] b;
         recv_byte(0, b, "t2 b0"); check("t2 addr", b, 8'hC3);
         bad = 0;
         repeat (50) begin
            step();
            if (!tvalid[0] || tdata[0] !== 8'h01) bad++;
         end
         check("t2 stall unstable cycles", bad, 0);
         recv_byte(0, b, "t2 b1"); check("t2 ts_hi", b, 8'h01);
         recv_byte(0, b, "t2 b2"); check("t2 ts_lo", b, 8'h23);
      end
      step(); check("t2 tvalid end", tvalid[0], 0);

      // Fill with stall: one event in the holding register plus 16 in the FIFO.
      for (int i = 0; i < 17; i++) handshake(0, 8'h10 + 8'(i), $sformatf("t3 ev%0d", i));
      check("t3 level full", level[0], 16);
      addr[0] = 8'h21; req[0] = 1'b1;
      repeat (20) step();
      check("t3 stalled ack", ack[0], 0);
      check("t3 level still full", level[0], 16);
      recv_addr(0, 8'h10, "t3 frame0");
      handshake(0, 8'h21, "t3 late");
      for (int i = 1; i < 18; i++) recv_addr(0, 8'h10 + 8'(i), $sformatf("t3 frame%0d", i));
      step();
      check("t3 tvalid end", tvalid[0], 0);
      check("t3 level end", level[0], 0);
      check("t3 overflow", ovf[0], 0);

      // Reset in the middle of a frame and of a handshake.
      handshake(0, 8'h3C, "t6 a");
      handshake(0, 8'h3D, "t6 b");
      begin
         logic [7:0] b;
         recv_byte(0, b, "t6 b0"); check("t6 addr", b, 8'h3C);
      end
      addr[0] = 8'h3E; req[0] = 1'b1;
      step();
      check("t6 ack before reset", ack[0], 1);
      #2 rst[0] = 1'b1;
      #1 check_idle(0, "t6 async reset");
      step();
      req[0] = 1'b0; rst[0] = 1'b0;
      step();
      check_idle(0, "t6 after reset");
      ts_clear[0] = 1'b1; step(); ts_clear[0] = 1'b0;
      repeat (8) step();
      handshake(0, 8'h5C, "t6 clean");
      recv_frame(0, 8'h5C, 16'h0002, "t6 frame");
      step(); check("t6 tvalid end", tvalid[0], 0);

      // Drop on full: 21 events, 4 dropped; then saturate the counter.
      for (int i = 0; i < 21; i++) handshake(1, 8'h40 + 8'(i), $sformatf("t4 ev%0d", i));
      check("t4 overflow 4", ovf[1], 4);
      check("t4 level full", level[1], 16);
      for (int k = 0; k < 300; k++) handshake(1, 8'hEE, "t4 drop");
      check("t4 overflow saturated", ovf[1], 255);
      check("t4 level unchanged", level[1], 16);
      for (int i = 0; i < 17; i++) recv_addr(1, 8'h40 + 8'(i), $sformatf("t4 frame%0d", i));
      step();
      check("t4 tvalid end", tvalid[1], 0);
      check("t4 level end", level[1], 0);

      // ts_clear on a tick cycle wins over the increment.
      ts_clear[1] = 1'b1; step(); ts_clear[1] = 1'b0;
      handshake(1, 8'h77, "t5 clear");
      recv_frame(1, 8'h77, 16'h0000, "t5 clear frame");

      // Wrap: events captured at 0xFFFE and two cycles later at 0x0000.
      ts_clear[1] = 1'b1; step(); ts_clear[1] = 1'b0;
      repeat (65534) step();
      handshake(1, 8'hA1, "t5 pre-wrap");
      handshake(1, 8'hA2, "t5 wrap");
      recv_frame(1, 8'hA1, 16'hFFFE, "t5 pre-wrap frame");
      recv_frame(1, 8'hA2, 16'h0000, "t5 wrap frame");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
